// File: rtl/fifo_read_ctrl.sv
`timescale 1ns/1ps
// fifo_read_ctrl
// Read-side controller for a synchronous FIFO. It issues FIFO reads (REN),
// captures the returned words into a small output buffer and presents them
// downstream on a valid/ready handshake. It also counts delivered frames.
//
// Ports
//   RCLK      : clock, shared with the FIFO read clock
//   RS_N      : asynchronous active-low reset
//   ENABLE    : 1 permits new FIFO reads
//   EF, PAE   : FIFO empty / partial-empty flags (both lag reads by 2 edges)
//   Q[8:0]    : FIFO read data, bit 8 = end-of-frame
//   REN       : active-low FIFO read enable (registered, drives REN1/REN2)
//   OE        : FIFO output enable (registered)
//   M_DATA/M_LAST/M_VALID/M_READY : downstream stream handshake
//   FRAME_CNT : number of frames delivered downstream (wraps)
module fifo_read_ctrl #(
  parameter int BUF_DEPTH = 4
) (
  input  logic       RCLK,
  input  logic       RS_N,
  input  logic       ENABLE,
  input  logic       EF,
  input  logic       PAE,
  input  logic [8:0] Q,
  output logic       REN,
  output logic       OE,
  output logic [7:0] M_DATA,
  output logic       M_LAST,
  output logic       M_VALID,
  input  logic       M_READY,
  output logic [15:0] FRAME_CNT
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = BUF_DEPTH[CW:0];

  typedef enum logic [2:0] {IDLE, BURST, STEP, WAIT1, WAIT2} state_t;

  state_t          state;
  logic            rd_vld_p0;
  logic [8:0]      buf_mem [BUF_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   occ;
  logic [1:0]      inflight;
  logic [CW:0]     need;
  logic [8:0]      head;
  logic            push;
  logic            pop;
  logic            can_read;

  assign head    = buf_mem[rd_ptr];
  assign M_VALID = (occ != '0);
  // Data outputs are forced to zero while the buffer is empty so that reset
  // clears them without having to reset the storage array.
  assign M_DATA  = M_VALID ? head[7:0] : 8'h00;
  assign M_LAST  = M_VALID & head[8];

  assign push = rd_vld_p0;
  assign pop  = M_VALID & M_READY;

  // Reads committed but not yet in the buffer: one for the current REN=0
  // cycle (read happens at the coming edge) and one whose data is on Q now.
  assign inflight = {1'b0, ~REN} + {1'b0, rd_vld_p0};

  // Worst-case occupancy if one more read is issued, crediting this cycle's pop.
  assign need = {1'b0, occ} - {{CW{1'b0}}, pop}
              + {{(CW-1){1'b0}}, inflight} + {{CW{1'b0}}, 1'b1};

  assign can_read = OE & ENABLE & ~EF & (need <= DEPTH_W);

  // Stage p0: a read sampled at the previous edge; its word is on Q now.
  always_ff @(posedge RCLK or negedge RS_N) begin
    if (!RS_N) begin
      state     <= IDLE;
      REN       <= 1'b1;
      OE        <= 1'b0;
      rd_vld_p0 <= 1'b0;
      occ       <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      FRAME_CNT <= 16'h0000;
    end else begin
      OE        <= 1'b1;
      rd_vld_p0 <= ~REN & ~EF;

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      occ <= occ + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

      if (pop && M_LAST) FRAME_CNT <= FRAME_CNT + 16'd1;

      // EF/PAE lag reads by two edges, so every read run is followed by at
      // least two REN-high cycles (WAIT1, WAIT2) before the flags are trusted.
      case (state)
        IDLE: begin
          if (can_read) begin
            REN   <= 1'b0;
            state <= PAE ? STEP : BURST;
          end else begin
            REN   <= 1'b1;
          end
        end
        BURST: begin
          if (can_read && !PAE) begin
            REN   <= 1'b0;
          end else begin
            REN   <= 1'b1;
            state <= WAIT1;
          end
        end
        STEP: begin
          REN   <= 1'b1;
          state <= WAIT1;
        end
        WAIT1: begin
          REN   <= 1'b1;
          state <= WAIT2;
        end
        WAIT2: begin
          REN   <= 1'b1;
          state <= IDLE;
        end
        default: begin
          REN   <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

  // Stage p1: word captured into the output buffer.
  always_ff @(posedge RCLK) begin
    if (push) buf_mem[wr_ptr] <= Q;
  end

endmodule

// File: tb/tb_fifo_read_ctrl.sv
`timescale 1ns/1ps
module tb_fifo_read_ctrl;

  logic        RCLK = 1'b0;
  logic        RS_N = 1'b1;
  logic        ENABLE = 1'b0;
  logic        EF = 1'b1;
  logic        PAE = 1'b1;
  logic [8:0]  Q = 9'h000;
  logic        REN;
  logic        OE;
  logic [7:0]  M_DATA;
  logic        M_LAST;
  logic        M_VALID;
  logic        M_READY = 1'b0;
  logic [15:0] FRAME_CNT;

  int errors = 0;
  int checks = 0;

  // Reference FIFO contents and the scoreboard of words read but not yet delivered.
  logic [8:0] fifo_q[$];
  logic [8:0] sb_q[$];
  int  hist1 = 0;
  int  hist2 = 0;
  int  pae_off = 7;
  int  n_reads = 0;
  logic [15:0] exp_frames = 16'h0000;

  int  cur_low = 0;
  int  low_cycles = 0;
  int  bursts = 0;
  int  hi_run = 0;
  bit  seen_low = 0;

  fifo_read_ctrl #(.BUF_DEPTH(4)) dut (
    .RCLK(RCLK), .RS_N(RS_N), .ENABLE(ENABLE), .EF(EF), .PAE(PAE), .Q(Q),
    .REN(REN), .OE(OE), .M_DATA(M_DATA), .M_LAST(M_LAST), .M_VALID(M_VALID),
    .M_READY(M_READY), .FRAME_CNT(FRAME_CNT)
  );

  always #5 RCLK = ~RCLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_true(input string name, input bit cond, input int val);
    checks++;
    if (!cond) begin
      errors++;
      $display("FAIL %s: observed %0d, condition not met", name, val);
    end
  endtask

  task automatic load_word(input logic [8:0] w);
    fifo_q.push_back(w);
  endtask

  // FIFO model: a read happens at an edge with REN=0 and EF=0; the word
  // appears on Q after the edge. Flags reflect the count from two edges back.
  initial begin
    logic ren_s, ef_s;
    logic [8:0] w;
    forever begin
      @(posedge RCLK);
      ren_s = REN;
      ef_s  = EF;
      #1;
      if (!RS_N) begin
        fifo_q.delete();
        sb_q.delete();
        hist1 = 0;
        hist2 = 0;
      end else if (!ren_s && !ef_s) begin
        if (fifo_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL fifo_underflow: read with %0d words, required at least 1", fifo_q.size());
        end else begin
          w = fifo_q.pop_front();
          Q = w;
          sb_q.push_back(w);
          n_reads++;
        end
      end
      EF    = (hist2 == 0);
      PAE   = (hist2 <= pae_off);
      hist2 = hist1;
      hist1 = fifo_q.size();
    end
  end

  // Monitor: compares delivered words, frame count, hold stability and REN rules.
  initial begin
    logic [8:0] w;
    logic [8:0] prev_out;
    bit prev_hold;
    prev_hold = 0;
    prev_out  = '0;
    forever begin
      @(negedge RCLK);
      if (RS_N) begin
        if (prev_hold && M_VALID)
          check("hold_stable", {23'd0, M_LAST, M_DATA}, {23'd0, prev_out});
        if (M_VALID && M_READY) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got 0x%0h expected no word", {M_LAST, M_DATA});
          end else begin
            w = sb_q.pop_front();
            check("out_word", {23'd0, M_LAST, M_DATA}, {23'd0, w});
            check("frame_cnt", {16'd0, FRAME_CNT}, {16'd0, exp_frames});
            if (w[8]) exp_frames = exp_frames + 16'd1;
          end
        end
        prev_hold = M_VALID && !M_READY;
        prev_out  = {M_LAST, M_DATA};
        if (!REN) begin
          check_true("ren_while_empty", EF == 1'b0, int'(EF));
          if (seen_low && cur_low == 0) check_true("ren_gap", hi_run >= 2, hi_run);
          cur_low++;
          if (cur_low == 2) bursts++;
          low_cycles++;
          seen_low = 1;
          hi_run   = 0;
        end else begin
          cur_low = 0;
          hi_run++;
        end
      end else begin
        prev_hold  = 0;
        seen_low   = 0;
        cur_low    = 0;
        hi_run     = 0;
        exp_frames = 16'h0000;
      end
    end
  end

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while ((fifo_q.size() != 0 || sb_q.size() != 0) && n < budget) begin
      @(negedge RCLK);
      n++;
    end
    check_true(name, n < budget, n);
    repeat (3) @(posedge RCLK);
    #2;
  endtask

  task automatic do_reset();
    RS_N = 1'b0;
    #1;
    check("rst_ren", {31'd0, REN}, 32'd1);
    check("rst_oe", {31'd0, OE}, 32'd0);
    check("rst_m_valid", {31'd0, M_VALID}, 32'd0);
    check("rst_m_data", {24'd0, M_DATA}, 32'd0);
    check("rst_m_last", {31'd0, M_LAST}, 32'd0);
    check("rst_frame_cnt", {16'd0, FRAME_CNT}, 32'd0);
    repeat (2) @(posedge RCLK);
    #3;
    RS_N = 1'b1;
    #1;
    check("release_oe_low", {31'd0, OE}, 32'd0);
    check("release_ren_high", {31'd0, REN}, 32'd1);
    @(posedge RCLK);
    #1;
    check("oe_after_edge", {31'd0, OE}, 32'd1);
    check("ren_at_oe_edge", {31'd0, REN}, 32'd1);
    #1;
  endtask

  initial begin
    int base_reads, base_bursts, base_low, n;
    #1;
    do_reset();
    ENABLE  = 1'b1;
    M_READY = 1'b1;

    // Three words in step mode, one frame.
    pae_off = 7;
    base_reads  = n_reads;
    base_bursts = bursts;
    load_word(9'h011); load_word(9'h022); load_word(9'h133);
    wait_drain("step3_drain", 300);
    check("step3_reads", n_reads - base_reads, 3);
    check("step3_no_burst", bursts - base_bursts, 0);
    check("step3_frames", {16'd0, FRAME_CNT}, 32'd1);
    check("step3_valid_low", {31'd0, M_VALID}, 32'd0);

    // Twenty words: burst while PAE=0, then step mode.
    base_reads  = n_reads;
    base_bursts = bursts;
    for (int i = 0; i < 20; i++) load_word((i == 19) ? 9'h1A0 + 9'(i) : 9'h0A0 + 9'(i));
    wait_drain("burst20_drain", 500);
    check("burst20_reads", n_reads - base_reads, 20);
    check_true("burst20_back_to_back", bursts > base_bursts, bursts - base_bursts);
    check("burst20_frames", {16'd0, FRAME_CNT}, 32'd2);

    // Downstream stalled: buffer fills with exactly four reads.
    M_READY = 1'b0;
    base_reads = n_reads;
    for (int i = 0; i < 10; i++) load_word((i == 9) ? 9'h149 : 9'h040 + 9'(i));
    repeat (40) @(posedge RCLK);
    #2;
    check("stall_reads", n_reads - base_reads, 4);
    check("stall_valid", {31'd0, M_VALID}, 32'd1);
    check("stall_head", {24'd0, M_DATA}, 32'h40);
    M_READY = 1'b1;
    wait_drain("stall_drain", 300);
    check("stall_total_reads", n_reads - base_reads, 10);
    check("stall_frames", {16'd0, FRAME_CNT}, 32'd3);

    // ENABLE dropped in the middle of a burst.
    for (int i = 0; i < 30; i++) load_word((i == 29) ? 9'h1C0 + 9'(i) : 9'h0C0 + 9'(i));
    n = 0;
    while (cur_low < 2 && n < 100) begin
      @(posedge RCLK);
      #2;
      n++;
    end
    check_true("disable_burst_seen", n < 100, n);
    ENABLE = 1'b0;
    @(posedge RCLK);
    #2;
    base_low   = low_cycles;
    base_reads = n_reads;
    repeat (30) @(posedge RCLK);
    #2;
    check("disable_no_ren", low_cycles - base_low, 0);
    check("disable_no_reads", n_reads - base_reads, 0);
    check("disable_captured", sb_q.size(), 0);
    check("disable_drained", {31'd0, M_VALID}, 32'd0);
    ENABLE = 1'b1;
    wait_drain("disable_resume_drain", 400);
    check("disable_frames", {16'd0, FRAME_CNT}, 32'd4);

    // Reset pulsed in the middle of a burst.
    base_reads = n_reads;
    for (int i = 0; i < 20; i++) load_word((i == 2 || i == 19) ? 9'h150 + 9'(i) : 9'h050 + 9'(i));
    n = 0;
    while (!((n_reads - base_reads) >= 6 && !REN) && n < 200) begin
      @(posedge RCLK);
      #2;
      n++;
    end
    check_true("reset_burst_seen", n < 200, n);
    do_reset();
    check("reset_flushed", fifo_q.size() + sb_q.size(), 0);

    // Randomised traffic against the reference model.
    for (int r = 0; r < 3; r++) begin
      pae_off = $urandom_range(2, 8);
      for (int c = 0; c < 600; c++) begin
        @(posedge RCLK);
        #2;
        M_READY = ($urandom_range(0, 3) != 0);
        ENABLE  = ($urandom_range(0, 9) != 0);
        if ($urandom_range(0, 7) == 0) begin
          n = $urandom_range(1, 6);
          for (int k = 0; k < n; k++)
            load_word({($urandom_range(0, 3) == 0), 8'($urandom_range(0, 255))});
        end
      end
      ENABLE  = 1'b1;
      M_READY = 1'b1;
      wait_drain("random_drain", 2000);
      check("random_frames", {16'd0, FRAME_CNT}, {16'd0, exp_frames});
    end

    // Frame counter wrap.
    pae_off = 7;
    do_reset();
    for (int i = 0; i < 65535; i++) load_word({1'b1, 8'(i)});
    wait_drain("wrap_fill_drain", 70000);
    check("wrap_ffff", {16'd0, FRAME_CNT}, 32'h0000FFFF);
    load_word(9'h1EE);
    wait_drain("wrap_last_drain", 200);
    check("wrap_zero", {16'd0, FRAME_CNT}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
